pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_if.sv | 14 +
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 tb/tb_pipe_stage_skid.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying a {ctrl, data} pipeline beat.
// master drives the beat, slave answers with ready.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Registered pipeline stage with one skid entry: in_ready depends only on state,
// so there is no combinational ready path from downstream to upstream.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stat_clr,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   accept;
  logic   deliver;
  logic   stall;

  assign in_beat  = {up.ctrl, up.data};

  assign up.ready = (state != FULL);
  assign dn.valid = (state != EMPTY);
  assign dn.ctrl  = main_q.ctrl;
  assign dn.data  = main_q.data;

  assign accept   = up.valid & up.ready;
  assign deliver  = dn.valid & dn.ready;
  assign stall    = dn.valid & ~dn.ready;

  // Main entry always holds the oldest beat; the skid entry only fills when
  // a beat arrives while the main entry is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so outputs read zero during reset.
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      main_q.ctrl <= '0;
      skid_q.ctrl <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the
      // pre-edge values, independent of statement order.
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_beat;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_q <= in_beat;
          end else if (accept) begin
            skid_q <= in_beat;
            state  <= FULL;
          end else if (deliver) begin
            main_q.ctrl <= '0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: begin
          main_q.ctrl <= '0;
          skid_q.ctrl <= '0;
          state       <= EMPTY;
        end
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment, flush is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a randomized run against a
// queue-based model of a two-deep in-order buffer.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             stat_clr;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stat_clr  (stat_clr),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the stage is a two-deep FIFO; the head is what is shown.
  beat_t             q[$];
  int                m_cnt;
  logic [DATA_W-1:0] m_data;

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_data = '0;
  endtask

  task automatic model_step();
    bit acc;
    bit del;
    beat_t b;
    acc = up_if.valid && (q.size() < 2);
    del = (q.size() > 0) && dn_if.ready;
    if (stat_clr) m_cnt = 0;
    else if ((q.size() > 0) && !dn_if.ready && (m_cnt < CNT_MAX)) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (del) void'(q.pop_front());
      if (acc) begin
        b.ctrl = up_if.ctrl;
        b.data = up_if.data;
        q.push_back(b);
      end
    end
    if (q.size() > 0) m_data = q[0].data;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    flush       = 1'b0;
    stat_clr    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    drive(1'b1, 8'hA5, 32'h5555_5555);
    dn_if.ready = 1'b1;
    #2;
    tests_run++; if (dn_if.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", dn_if.valid); end
    tests_run++; if (dn_if.ctrl !== '0) begin tests_failed++; $display("FAIL reset_ctrl: got %h want 00", dn_if.ctrl); end
    tests_run++; if (dn_if.data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", dn_if.data); end
    tests_run++; if (up_if.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", up_if.ready); end
    @(posedge clk); #1;
    tests_run++; if (dn_if.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_held_valid: got %b want 0", dn_if.valid); end
    tests_run++; if (stall_cnt !== '0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    apply_reset();
    tests_run++; if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset: valid %b ready %b want 0/1", dn_if.valid, up_if.ready); end
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h0F, 32'h1000 + i);
      tests_run++; if (up_if.ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready[%0d]: got %b want 1", i, up_if.ready); end
      cycle();
      tests_run++;
      if (dn_if.valid !== 1'b1 || dn_if.data !== 32'(32'h1000 + i) || dn_if.ctrl !== 8'h0F) begin
        tests_failed++;
        $display("FAIL stream_out[%0d]: got v=%b c=%h d=%h want v=1 c=0f d=%h", i, dn_if.valid, dn_if.ctrl, dn_if.data, 32'h1000 + i);
      end
    end
    drive(1'b0, '0, '0);
    cycle();
    tests_run++; if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0) begin tests_failed++; $display("FAIL stream_drain: v=%b c=%h want 0/00", dn_if.valid, dn_if.ctrl); end
    tests_run++; if (dn_if.data !== 32'h1007) begin tests_failed++; $display("FAIL stream_data_hold: got %h want 00001007", dn_if.data); end
    tests_run++; if (stall_cnt !== '0) begin tests_failed++; $display("FAIL stream_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_skid();
    dn_if.ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    cycle();
    drive(1'b1, 8'h22, 32'hB);
    cycle();
    tests_run++; if (up_if.ready !== 1'b0) begin tests_failed++; $display("FAIL skid_full_ready: got %b want 0", up_if.ready); end
    tests_run++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA || dn_if.ctrl !== 8'h11) begin tests_failed++; $display("FAIL skid_full_head: v=%b c=%h d=%h want 1/11/a", dn_if.valid, dn_if.ctrl, dn_if.data); end
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    cycle();
    tests_run++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hB || dn_if.ctrl !== 8'h22) begin tests_failed++; $display("FAIL skid_second: v=%b c=%h d=%h want 1/22/b", dn_if.valid, dn_if.ctrl, dn_if.data); end
    tests_run++; if (up_if.ready !== 1'b1) begin tests_failed++; $display("FAIL skid_ready_back: got %b want 1", up_if.ready); end
    cycle();
    tests_run++; if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0) begin tests_failed++; $display("FAIL skid_drain: v=%b c=%h want 0/00", dn_if.valid, dn_if.ctrl); end
    tests_run++; if (stall_cnt !== 4'd1) begin tests_failed++; $display("FAIL skid_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    cycle();
    drive(1'b1, 8'h22, 32'hB);
    cycle();
    drive(1'b1, 8'h33, 32'hC);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    tests_run++; if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0) begin tests_failed++; $display("FAIL flush_out: v=%b c=%h want 0/00", dn_if.valid, dn_if.ctrl); end
    tests_run++; if (up_if.ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %b want 1", up_if.ready); end
    tests_run++; if (dn_if.data !== 32'hA) begin tests_failed++; $display("FAIL flush_data_hold: got %h want 0000000a", dn_if.data); end
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++; if (dn_if.valid !== 1'b0 || dn_if.data === 32'hC) begin tests_failed++; $display("FAIL flush_no_c[%0d]: v=%b d=%h want v=0, no 0xc", i, dn_if.valid, dn_if.data); end
    end
  endtask

  task automatic test_stall_sat();
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    tests_run++; if (stall_cnt !== '0) begin tests_failed++; $display("FAIL sat_clr0: got %0d want 0", stall_cnt); end
    dn_if.ready = 1'b0;
    drive(1'b1, 8'h44, 32'h77);
    cycle();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      tests_run++;
      if (stall_cnt !== 4'((k < CNT_MAX) ? k : CNT_MAX)) begin
        tests_failed++;
        $display("FAIL sat_count[%0d]: got %0d want %0d", k, stall_cnt, (k < CNT_MAX) ? k : CNT_MAX);
      end
    end
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    tests_run++; if (stall_cnt !== '0) begin tests_failed++; $display("FAIL sat_clr_wins: got %0d want 0", stall_cnt); end
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    tests_run++; if (stall_cnt !== 4'd4 || dn_if.valid !== 1'b0) begin tests_failed++; $display("FAIL sat_flush: cnt %0d v %b want 4/0", stall_cnt, dn_if.valid); end
    cycle();
    tests_run++; if (stall_cnt !== 4'd4) begin tests_failed++; $display("FAIL sat_after_flush: got %0d want 4", stall_cnt); end
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    dn_if.ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    cycle();
    drive(1'b1, 8'h22, 32'hB);
    cycle();
    drive(1'b0, '0, '0);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || dn_if.data !== '0) begin tests_failed++; $display("FAIL areset_out: v=%b c=%h d=%h want all 0", dn_if.valid, dn_if.ctrl, dn_if.data); end
    tests_run++; if (up_if.ready !== 1'b1 || stall_cnt !== '0) begin tests_failed++; $display("FAIL areset_ready_cnt: ready %b cnt %0d want 1/0", up_if.ready, stall_cnt); end
    #1;
    rst_n = 1'b1;
    model_reset();
    dn_if.ready = 1'b1;
    drive(1'b1, 8'h55, 32'hD);
    cycle();
    tests_run++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hD || dn_if.ctrl !== 8'h55) begin tests_failed++; $display("FAIL areset_first: v=%b c=%h d=%h want 1/55/d", dn_if.valid, dn_if.ctrl, dn_if.data); end
    drive(1'b0, '0, '0);
    cycle();
    tests_run++; if (dn_if.valid !== 1'b0) begin tests_failed++; $display("FAIL areset_stale: v=%b d=%h want v=0", dn_if.valid, dn_if.data); end
  endtask

  task automatic test_random();
    logic [CTRL_W-1:0] exp_ctrl;
    apply_reset();
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom % 4) != 0, CTRL_W'($urandom), $urandom);
      dn_if.ready = ($urandom % 3) != 0;
      flush       = ($urandom % 50) == 0;
      stat_clr    = ($urandom % 200) == 0;
      tests_run++; if (up_if.ready !== (q.size() < 2)) begin tests_failed++; $display("FAIL rand_ready[%0d]: got %b want %b", n, up_if.ready, q.size() < 2); end
      cycle();
      exp_ctrl = (q.size() > 0) ? q[0].ctrl : '0;
      tests_run++; if (dn_if.valid !== (q.size() > 0)) begin tests_failed++; $display("FAIL rand_valid[%0d]: got %b want %b", n, dn_if.valid, q.size() > 0); end
      tests_run++; if (dn_if.ctrl !== exp_ctrl) begin tests_failed++; $display("FAIL rand_ctrl[%0d]: got %h want %h", n, dn_if.ctrl, exp_ctrl); end
      tests_run++; if (dn_if.data !== m_data) begin tests_failed++; $display("FAIL rand_data[%0d]: got %h want %h", n, dn_if.data, m_data); end
      tests_run++; if (stall_cnt !== 4'(m_cnt)) begin tests_failed++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, stall_cnt, m_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall_sat();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
